inst_stream_gen: RTL and testbench

- Synthesizable MIPS instruction-stream generator.
- Feeds the instruction input of the single-cycle cpu in place of a hand-sequenced bench.
- Emits the two-register init sequence, then N arithmetic terms (Fibonacci or doubling), then pipeline-drain NOPs.
- Uses a valid/ready handshake so the cpu or a stall-capable successor can throttle it.

---
 rtl/inst_stream_gen.sv | 199 +++++++++++++++++++
 tb/tb_inst_stream_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_stream_gen.sv
// Instruction-stream generator: two addi inits, N add terms (Fibonacci or doubling),
// then drain NOPs, presented on a registered valid/ready interface.
module inst_stream_gen #(
    parameter logic [4:0]  REG_A      = 5'd1,
    parameter logic [4:0]  REG_B      = 5'd2,
    parameter logic [15:0] INIT_VAL   = 16'd1,
    parameter int          CNT_W      = 8,
    parameter int          FLUSH_NOPS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [CNT_W-1:0]   n_terms,
    input  logic               inst_ready,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic               busy,
    output logic               done,
    output logic [CNT_W+1:0]   inst_count
);

    localparam int CW = CNT_W + 2;
    localparam int FW = (FLUSH_NOPS > 1) ? $clog2(FLUSH_NOPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_A,
        S_INIT_B,
        S_TERMS,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q,      state_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q,       inst_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic [CW-1:0]     inst_count_q, inst_count_d;
    logic [CNT_W-1:0]  n_terms_q,    n_terms_d;
    logic              mode_q,       mode_d;
    logic [CNT_W-1:0]  idx_q,        idx_d;
    logic [FW-1:0]     flush_cnt_q,  flush_cnt_d;

    logic xfer;
    logic enter_tail;
    logic enter_done;

    function automatic logic [31:0] addi_word(input logic [4:0] rt);
        return {6'b001000, 5'd0, rt, INIT_VAL};
    endfunction

    // Doubling always targets REG_A; Fibonacci alternates the destination on index parity.
    function automatic logic [31:0] term_word(input logic [CNT_W-1:0] i, input logic m);
        logic [4:0] rt;
        logic [4:0] rd;
        rt = m ? REG_A : REG_B;
        rd = (m || !i[0]) ? REG_A : REG_B;
        return {6'b000000, REG_A, rt, rd, 5'd0, 6'b100000};
    endfunction

    assign xfer = inst_valid_q && inst_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        inst_count_d = inst_count_q;
        n_terms_d    = n_terms_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        flush_cnt_d  = flush_cnt_q;
        enter_tail   = 1'b0;
        enter_done   = 1'b0;

        if (xfer) begin
            inst_count_d = inst_count_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_terms_d    = n_terms;
                    mode_d       = mode;
                    inst_count_d = '0;
                    idx_d        = '0;
                    state_d      = S_INIT_A;
                    inst_valid_d = 1'b1;
                    inst_d       = addi_word(REG_A);
                    busy_d       = 1'b1;
                end
            end
            S_INIT_A: begin
                if (xfer) begin
                    state_d = S_INIT_B;
                    inst_d  = addi_word(REG_B);
                end
            end
            S_INIT_B: begin
                if (xfer) begin
                    if (n_terms_q != '0) begin
                        state_d = S_TERMS;
                        idx_d   = '0;
                        inst_d  = term_word('0, mode_q);
                    end else begin
                        enter_tail = 1'b1;
                    end
                end
            end
            S_TERMS: begin
                if (xfer) begin
                    if (idx_q == n_terms_q - CNT_W'(1)) begin
                        enter_tail = 1'b1;
                    end else begin
                        idx_d  = idx_q + CNT_W'(1);
                        inst_d = term_word(idx_q + CNT_W'(1), mode_q);
                    end
                end
            end
            S_FLUSH: begin
                if (xfer) begin
                    if (int'(flush_cnt_q) == FLUSH_NOPS - 1) begin
                        enter_done = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                inst_valid_d = 1'b0;
                inst_d       = '0;
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                inst_valid_d = 1'b0;
                inst_d       = '0;
            end
        endcase

        // With no drain NOPs configured the last term goes straight to DONE.
        if (enter_tail) begin
            if (FLUSH_NOPS != 0) begin
                state_d     = S_FLUSH;
                flush_cnt_d = '0;
                inst_d      = '0;
            end else begin
                enter_done = 1'b1;
            end
        end

        if (enter_done) begin
            state_d      = S_DONE;
            inst_valid_d = 1'b0;
            inst_d       = '0;
            done_d       = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            inst_count_q <= '0;
            n_terms_q    <= '0;
            mode_q       <= 1'b0;
            idx_q        <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            inst_count_q <= inst_count_d;
            n_terms_q    <= n_terms_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign inst_count = inst_count_q;

endmodule

// File: tb/tb_inst_stream_gen.sv
// Self-checking bench for inst_stream_gen: vector table, reset corner case and random runs
// compared against a queue-based model of the expected instruction stream.
module tb_inst_stream_gen;

    localparam int RA   = 1;
    localparam int RB   = 2;
    localparam int IV   = 1;
    localparam int NOPS = 3;

    localparam logic [31:0] ADDI_A  = (32'd8 << 26) | (32'(RA) << 16) | 32'(IV);
    localparam logic [31:0] ADDI_B  = (32'd8 << 26) | (32'(RB) << 16) | 32'(IV);
    localparam logic [31:0] ADD_A   = (32'(RA) << 21) | (32'(RB) << 16) | (32'(RA) << 11) | 32'h20;
    localparam logic [31:0] ADD_B   = (32'(RA) << 21) | (32'(RB) << 16) | (32'(RB) << 11) | 32'h20;
    localparam logic [31:0] ADD_DBL = (32'(RA) << 21) | (32'(RA) << 16) | (32'(RA) << 11) | 32'h20;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [7:0]  n_terms;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic [9:0]  inst_count;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] log_q[$];

    inst_stream_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .n_terms    (n_terms),
        .inst_ready (inst_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] n;
        bit         rnd_ready;
        bit         poke_start;
        int         exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one complete sequence starting at a negedge with the DUT idle.
    task automatic run_seq(input logic m, input logic [7:0] n, input bit rnd, input bit poke,
                           input int exp_cnt);
        logic [31:0] expq[$];
        logic [31:0] prev_inst;
        bit          prev_stall;
        bit          seen_done;
        int          last_xfer;
        int          xfers;
        int          cyc;

        expq.push_back(ADDI_A);
        expq.push_back(ADDI_B);
        for (int i = 0; i < int'(n); i++) begin
            expq.push_back(m ? ADD_DBL : ((i % 2 == 0) ? ADD_A : ADD_B));
        end
        for (int i = 0; i < NOPS; i++) expq.push_back(32'h0);

        log_q.delete();
        prev_stall = 1'b0;
        prev_inst  = '0;
        seen_done  = 1'b0;
        last_xfer  = -1;
        xfers      = 0;
        cyc        = 0;

        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        n_terms    = n;
        inst_ready = 1'b1;
        @(negedge clk);
        check("start_count_clear", 32'(inst_count), 32'd0);
        check("start_valid", 32'(inst_valid), 32'd1);
        check("start_busy", 32'(busy), 32'd1);

        while (!seen_done && cyc < 2000) begin
            if (done) begin
                seen_done = 1'b1;
                check("done_after_last", 32'(cyc), 32'(last_xfer + 1));
                check("done_count", 32'(inst_count), 32'(exp_cnt));
                check("done_xfers", 32'(xfers), 32'(exp_cnt));
                check("done_leftover", 32'(expq.size()), 32'd0);
                check("done_valid", 32'(inst_valid), 32'd0);
                check("done_inst", inst, 32'h0);
                check("done_busy", 32'(busy), 32'd1);
                start = poke;
            end else begin
                check("run_busy", 32'(busy), 32'd1);
                if (prev_stall) begin
                    check("stall_valid", 32'(inst_valid), 32'd1);
                    check("stall_hold", inst, prev_inst);
                end
                if (!rnd) check("no_bubble", 32'(inst_valid), 32'd1);
                start      = poke ? 1'($urandom) : 1'b0;
                mode       = 1'($urandom);
                n_terms    = 8'($urandom);
                inst_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (inst_valid && inst_ready) begin
                    if (expq.size() == 0) begin
                        check("extra_word", inst, 32'hDEADBEEF);
                    end else begin
                        check("word", inst, expq.pop_front());
                    end
                    log_q.push_back(inst);
                    last_xfer = cyc;
                    xfers++;
                end
                prev_stall = inst_valid && !inst_ready;
                prev_inst  = inst;
            end
            cyc++;
            @(negedge clk);
        end

        if (!seen_done) begin
            check("timeout_no_done", 32'd0, 32'd1);
        end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_valid", 32'(inst_valid), 32'd0);
            check("idle_inst", inst, 32'h0);
            check("idle_count_hold", 32'(inst_count), 32'(exp_cnt));
        end
        start      = 1'b0;
        inst_ready = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{m: 1'b0, n: 8'd10,  rnd_ready: 1'b0, poke_start: 1'b0, exp_cnt: 15};
        vecs[1] = '{m: 1'b1, n: 8'd4,   rnd_ready: 1'b0, poke_start: 1'b0, exp_cnt: 9};
        vecs[2] = '{m: 1'b0, n: 8'd0,   rnd_ready: 1'b0, poke_start: 1'b0, exp_cnt: 5};
        vecs[3] = '{m: 1'b0, n: 8'd5,   rnd_ready: 1'b1, poke_start: 1'b0, exp_cnt: 10};
        vecs[4] = '{m: 1'b0, n: 8'd10,  rnd_ready: 1'b0, poke_start: 1'b1, exp_cnt: 15};
        vecs[5] = '{m: 1'b1, n: 8'd255, rnd_ready: 1'b0, poke_start: 1'b0, exp_cnt: 260};

        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        n_terms    = 8'd0;
        inst_ready = 1'b1;

        #1;
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(inst_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].m, vecs[i].n, vecs[i].rnd_ready, vecs[i].poke_start, vecs[i].exp_cnt);
            if (i == 0 && log_q.size() == 15) begin
                check("fib_w0", log_q[0], 32'h20010001);
                check("fib_w1", log_q[1], 32'h20020001);
                check("fib_w2", log_q[2], 32'h00220820);
                check("fib_w3", log_q[3], 32'h00221020);
                check("fib_w14", log_q[14], 32'h00000000);
            end
            if (i == 1 && log_q.size() == 9) begin
                check("dbl_w2", log_q[2], 32'h00210820);
                check("dbl_w5", log_q[5], 32'h00210820);
            end
            if (i == 2 && log_q.size() == 5) begin
                check("zero_w2", log_q[2], 32'h00000000);
            end
        end

        // Asynchronous reset in the middle of TERMS.
        @(negedge clk);
        start   = 1'b1;
        mode    = 1'b0;
        n_terms = 8'd10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_term2", inst, 32'h00220820);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_count", 32'(inst_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle_valid", 32'(inst_valid), 32'd0);
            check("post_rst_idle_busy", 32'(busy), 32'd0);
            check("post_rst_idle_done", 32'(done), 32'd0);
        end

        for (int r = 0; r < 10; r++) begin
            logic [7:0] rn;
            rn = 8'($urandom_range(0, 20));
            run_seq(1'($urandom), rn, 1'($urandom), 1'($urandom), 2 + int'(rn) + NOPS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
